// File: rtl/pipe_ctrl_gen_pkg.sv
// Shared constants for the OpenMIPS pipeline control unit: reset and stall
// levels, stage indices, default exception vector and FSM encodings.
package pipe_ctrl_gen_pkg;

    // Signal levels
    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;
    localparam logic Stop       = 1'b1;
    localparam logic NoStop     = 1'b0;

    // Stall mask bit positions (bit k is the register after stage k)
    localparam int StagePc  = 0;
    localparam int StageIf  = 1;
    localparam int StageId  = 2;
    localparam int StageEx  = 3;
    localparam int StageMem = 4;
    localparam int StageWb  = 5;

    // Redirect target for non-ERET exceptions
    localparam logic [31:0] ExcVectorDefault = 32'h0000_0020;

    // Flush sequencer states
    localparam logic [0:0] StateIdle  = 1'b0;
    localparam logic [0:0] StateFlush = 1'b1;

    // ERET returns to the saved EPC; every other exception goes to the vector
    function automatic logic [31:0] flush_target(
        input logic        eret,
        input logic [31:0] epc,
        input logic [31:0] vector
    );
        logic [31:0] target;
        if (eret) begin
            target = epc;
        end else begin
            target = vector;
        end
        return target;
    endfunction

endpackage

// File: rtl/pipe_ctrl_gen_stall_mon.sv
// Stall monitor: saturating count of stalled cycles plus a sticky watchdog
// that flags a run of STALL_TIMEOUT consecutive stalled cycles.
module pipe_stall_mon
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_any,
    input  logic             flush,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_timeout
);

    localparam int RUN_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic WDOG_EN = (STALL_TIMEOUT > 0);
    localparam logic [RUN_W-1:0] RUN_LIMIT = WDOG_EN ? RUN_W'(STALL_TIMEOUT - 1) : {RUN_W{1'b0}};
    localparam logic [RUN_W-1:0] RUN_MAX   = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [RUN_W-1:0] run_r;
    logic             timeout_r;
    logic             stall_active_s;

    // A flush cycle never counts as a stalled cycle
    always_comb begin
        stall_active_s = stall_any & ~flush;
    end

    // Performance counter: clear beats increment, saturate at all-ones
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (perf_clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (stall_active_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Consecutive-stall run length, cleared by any non-stalled cycle
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            run_r <= {RUN_W{1'b0}};
        end else if (!stall_active_s) begin
            run_r <= {RUN_W{1'b0}};
        end else if (run_r != RUN_MAX) begin
            run_r <= run_r + RUN_ONE;
        end else begin
            run_r <= run_r;
        end
    end

    // Sticky timeout flag; only reset clears it
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            timeout_r <= 1'b0;
        end else if (WDOG_EN && stall_active_s && (run_r >= RUN_LIMIT)) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign stall_cnt     = cnt_r;
    assign stall_timeout = timeout_r;

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline control unit: prefix stall mask, exception/ERET flush sequencer
// with redirect PC, and a stall performance monitor.
module pipe_ctrl_gen
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int          NUM_STAGES    = 6,
    parameter int          FLUSH_CYCLES  = 1,
    parameter logic [31:0] EXC_VECTOR    = ExcVectorDefault,
    parameter int          CNT_W         = 32,
    parameter int          STALL_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallreq,
    input  logic                  excp_valid,
    input  logic                  excp_eret,
    input  logic [31:0]           epc_in,
    input  logic                  perf_clr,
    output logic [NUM_STAGES-1:0] stall,
    output logic                  flush,
    output logic [31:0]           new_pc,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic                  stall_timeout
);

    localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic MULTI_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [FCNT_W-1:0] FCNT_LOAD = MULTI_FLUSH ? FCNT_W'(FLUSH_CYCLES - 2) : {FCNT_W{1'b0}};
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

    logic [0:0]            state_r;
    logic [FCNT_W-1:0]     fcnt_r;
    logic [31:0]           pc_lat_r;
    logic [NUM_STAGES-1:0] mask_s;
    logic [31:0]           exc_pc_s;
    logic                  stall_any_s;

    // Highest requesting stage stalls itself and everything upstream of it
    genvar k;
    generate
        for (k = 0; k < NUM_STAGES; k++) begin : g_mask
            assign mask_s[k] = |stallreq[NUM_STAGES-1:k];
        end
    endgenerate

    // Redirect target for an exception accepted this cycle
    always_comb begin
        exc_pc_s = flush_target(excp_eret, epc_in, EXC_VECTOR);
    end

    // Output priority: reset, then flush (new or in progress), then stall
    always_comb begin
        if (rst == RstEnable) begin
            stall  = {NUM_STAGES{NoStop}};
            flush  = 1'b0;
            new_pc = 32'h0000_0000;
        end else if (state_r == StateFlush) begin
            stall  = {NUM_STAGES{NoStop}};
            flush  = 1'b1;
            new_pc = pc_lat_r;
        end else if (excp_valid) begin
            stall  = {NUM_STAGES{NoStop}};
            flush  = 1'b1;
            new_pc = exc_pc_s;
        end else begin
            stall  = mask_s;
            flush  = 1'b0;
            new_pc = 32'h0000_0000;
        end
    end

    // Flush sequencer: holds flush for the remaining FLUSH_CYCLES-1 cycles
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_r  <= StateIdle;
            fcnt_r   <= {FCNT_W{1'b0}};
            pc_lat_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                StateIdle: begin
                    if (excp_valid && MULTI_FLUSH) begin
                        state_r  <= StateFlush;
                        fcnt_r   <= FCNT_LOAD;
                        pc_lat_r <= exc_pc_s;
                    end else begin
                        state_r  <= StateIdle;
                    end
                end
                StateFlush: begin
                    if (fcnt_r == {FCNT_W{1'b0}}) begin
                        state_r <= StateIdle;
                    end else begin
                        fcnt_r  <= fcnt_r - FCNT_ONE;
                    end
                end
                default: begin
                    state_r <= StateIdle;
                    fcnt_r  <= {FCNT_W{1'b0}};
                end
            endcase
        end
    end

    // Any stalled register counts as a stalled cycle
    always_comb begin
        stall_any_s = (stall != {NUM_STAGES{NoStop}});
    end

    pipe_stall_mon #(
        .CNT_W         (CNT_W),
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_stall_mon (
        .clk           (clk),
        .rst           (rst),
        .stall_any     (stall_any_s),
        .flush         (flush),
        .perf_clr      (perf_clr),
        .stall_cnt     (stall_cnt),
        .stall_timeout (stall_timeout)
    );

endmodule

// File: doc/pipe_ctrl_gen.md
Name: pipe_ctrl_gen

Overview:
Parametrised pipeline control unit for the OpenMIPS core, the next generation of the fixed 6-bit stall controller.
- Merges per-stage stall requests into a prefix stall mask for any stage count.
- Adds an exception/ERET flush sequencer with a configurable flush length and a redirect PC.
- Adds a saturating stall performance counter and a sticky stall watchdog.
- Sits beside the pipeline and drives stall/flush to the pc_reg, if_id, id_ex, ex_mem and mem_wb registers.

Parameters:
NUM_STAGES, 6, number of pipeline stages. Bit 0 is PC; bit k is the register after stage k.
FLUSH_CYCLES, 1, cycles flush stays high per accepted exception (>=1).
EXC_VECTOR, 32'h0000_0020, redirect PC for non-ERET exceptions.
CNT_W, 32, width of the stall performance counter.
STALL_TIMEOUT, 1024, consecutive stall cycles before stall_timeout is set. 0 disables the watchdog.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
stallreq  in  NUM_STAGES  bit k=1: stage k requests a stall
excp_valid  in  1  exception/ERET committed this cycle
excp_eret  in  1  qualifies excp_valid as ERET
epc_in  in  32  return address used on ERET
perf_clr  in  1  synchronous clear of stall_cnt
stall  out  NUM_STAGES  stall mask to pipeline registers
flush  out  1  flush all pipeline registers
new_pc  out  32  redirect target, valid while flush=1
stall_cnt  out  CNT_W  saturating count of cycles with stall!=0
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: synchronous, active-high, on clk rising edge. rst=1 forces stall=0, flush=0, new_pc=0 combinationally in the same cycle. Next edge: FSM=IDLE, all counters=0, stall_timeout=0.
- Stall mask (combinational, zero latency): stall[k] = OR(stallreq[NUM_STAGES-1:k]).
  - The highest requesting stage stalls itself and every earlier stage.
  - Examples (N=6): stallreq[2] -> 6'b000111; stallreq[3] -> 6'b001111.
- FSM states: IDLE, FLUSH.
- IDLE:
  - excp_valid=1 -> flush=1 in the same cycle (combinational). new_pc = excp_eret ? epc_in : EXC_VECTOR. stall forced to 0.
  - If FLUSH_CYCLES>1: latch new_pc, load fcnt=FLUSH_CYCLES-2, go to FLUSH.
  - If FLUSH_CYCLES=1: stay in IDLE.
- FLUSH:
  - flush=1, new_pc=latched value, stall forced to 0.
  - excp_valid and stallreq are ignored; the exception is not queued.
  - fcnt==0 -> IDLE; otherwise fcnt decrements.
- Priority: rst > flush > stall. Exception and stall request in the same cycle: flush wins, stall=0.
- stall_cnt:
  - +1 on every edge where the output stall!=0.
  - Saturates at all-ones and never wraps.
  - perf_clr=1 loads 0 and wins over a same-cycle increment.
- Watchdog:
  - run counter +1 while stall!=0; cleared to 0 on any cycle with stall==0, and during flush.
  - When run reaches STALL_TIMEOUT-1 and stall is still !=0, stall_timeout <= 1. It stays set until rst; perf_clr does not clear it.
  - run saturates and never wraps.
  - STALL_TIMEOUT=0: the flag stays 0.
- Reset mid-FLUSH: abort immediately; the next non-reset cycle is IDLE with flush=0.
- Widths: run counter is clog2(STALL_TIMEOUT+1) bits; fcnt is clog2(FLUSH_CYCLES) bits (min 1).

Decomposition:
- Shared defines file gains:
  - RstEnable / Stop / NoStop level constants
  - stage index constants (PC=0, IF=1, ID=2, EX=3, MEM=4, WB=5)
  - default EXC_VECTOR
  - FSM state encodings IDLE=1'b0, FLUSH=1'b1
- One sub-module: pipe_stall_mon.
  - Contains the stall_cnt, watchdog run counter and sticky flag.
  - Inputs: clk, rst, stall_any, flush, perf_clr.
  - Parameters: CNT_W, STALL_TIMEOUT.

Test Plan:
1. Reset/mask: rst=1 with stallreq=6'b111111 -> stall=0. Release rst; stallreq=6'b000100 -> stall=6'b000111; stallreq=6'b001100 -> 6'b001111; stallreq=6'b100000 -> 6'b111111.
2. Exception: FLUSH_CYCLES=3, excp_valid=1, excp_eret=0, stallreq=6'b001000 at cycle T -> flush=1 for T..T+2, new_pc=32'h20, stall=0; second excp_valid at T+1 ignored; flush=0 at T+3.
3. ERET: excp_valid=1, excp_eret=1, epc_in=32'h8000_1234 -> new_pc=32'h8000_1234 in the same cycle; epc_in changed at T+1 does not alter latched new_pc.
4. Counter: 5 stall cycles -> stall_cnt=5; perf_clr plus stall in the same cycle -> 0. With CNT_W=3 and 10 stall cycles -> stall_cnt stays 7.
5. Watchdog: STALL_TIMEOUT=4, 3 stall cycles then 1 idle then 4 stall cycles -> stall_timeout rises after the 4th consecutive stall only and stays 1 through perf_clr; rst clears it.
6. Mid-flush reset: FLUSH_CYCLES=4, rst at T+1 -> flush=0 at T+1, IDLE at T+2, counters 0.
